// File: rtl/pipeline_regs_pkg.sv
// Shared definitions for the five-stage pipeline register slice.
// Holds the bubble instruction, RV32 opcode constants and the stage payload.
// Everything here is compile-time only; no logic, no latency, no flow control.
package pipeline_regs_pkg;

  // addi x0,x0,0 -- the canonical RV32I no-op used as the bubble instruction
  localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Payload carried between stages. Not every stage uses every field:
  // D carries pc/instr/valid, E carries everything, M/W drop opa_sel/pc_sel.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        rd_wren;
    logic [1:0]  wb_sel;
    logic        opa_sel;
    logic        pc_sel;
  } stage_t;

  // Bubble: no-op instruction, zero PC, invalid, all controls deasserted.
  function automatic stage_t bubble_payload(input logic [31:0] nop);
    stage_t s;
    s       = '0;
    s.instr = nop;
    return s;
  endfunction

endpackage

// File: rtl/pipeline_regs_stage.sv
// Purpose : one pipeline stage register with flush-over-stall priority.
// Latency : 1 cycle from i_d to o_q when neither held nor flushed.
// Backpr. : i_stall holds the current payload; i_flush (or reset) loads BUBBLE.
// Ports   : i_clk, i_reset (sync, active-high), i_stall, i_flush,
//           i_d (next payload), o_q (registered payload).
module pipe_stage_reg #(
  parameter type T      = logic [31:0],
  parameter T    BUBBLE = '0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_stall,
  input  logic i_flush,
  input  T     i_d,
  output T     o_q
);

  T r_q;

  // Reset and flush both insert a bubble; flush wins over stall.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_q <= BUBBLE;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipeline_regs.sv
// Purpose : F/D/E/M/W pipeline registers plus performance counters.
// Latency : 1 cycle per stage; an instruction at pc_F reaches W 4 edges later.
// Backpr. : per-stage Stall holds, per-stage Flush bubbles (flush wins); reset overrides both.
// Ports   : i_clk, i_reset; pc_next_F/instr_F from fetch; Stall*/Flush* from hazard unit;
//           *_D decoded controls in; per-stage pc/instr/valid/controls and counters out.
module pipeline_regs
  import pipeline_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] pc_next_F,
  input  logic [31:0] instr_F,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        StallE,
  input  logic        StallM,
  input  logic        StallW,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        FlushM,
  input  logic        FlushW,
  input  logic        rd_wren_D,
  input  logic        opa_sel_D,
  input  logic        pc_sel_D,
  input  logic [1:0]  wb_sel_D,
  output logic [31:0] pc_F,
  output logic [31:0] pc_D,
  output logic [31:0] pc_E,
  output logic [31:0] pc_M,
  output logic [31:0] pc_W,
  output logic [31:0] instr_D,
  output logic [31:0] instr_E,
  output logic [31:0] instr_M,
  output logic [31:0] instr_W,
  output logic        rd_wren_E,
  output logic        rd_wren_M,
  output logic        rd_wren_W,
  output logic        opa_sel_E,
  output logic        pc_sel_E,
  output logic [1:0]  wb_sel_E,
  output logic [1:0]  wb_sel_M,
  output logic [1:0]  wb_sel_W,
  output logic        valid_D,
  output logic        valid_E,
  output logic        valid_M,
  output logic        valid_W,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam stage_t BUBBLE = bubble_payload(NOP_INSTR);

  logic [31:0] r_pc_f;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  stage_t w_d_in, w_e_in, w_m_in;
  stage_t w_d_q, w_e_q, w_m_q, w_w_q;

  // Fetch PC: no flush, only hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc_f <= RESET_PC;
    end else if (!StallF) begin
      r_pc_f <= pc_next_F;
    end
  end

  // Stage inputs. Controls enter at E from the decoder; D carries none.
  always_comb begin
    w_d_in       = '0;
    w_d_in.pc    = r_pc_f;
    w_d_in.instr = instr_F;
    w_d_in.valid = 1'b1;

    w_e_in         = w_d_q;
    w_e_in.rd_wren = rd_wren_D;
    w_e_in.wb_sel  = wb_sel_D;
    w_e_in.opa_sel = opa_sel_D;
    w_e_in.pc_sel  = pc_sel_D;

    // opa_sel/pc_sel are consumed in E and not carried further
    w_m_in         = w_e_q;
    w_m_in.opa_sel = 1'b0;
    w_m_in.pc_sel  = 1'b0;
  end

  pipe_stage_reg #(.T(stage_t), .BUBBLE(BUBBLE)) u_stage_d (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(StallD), .i_flush(FlushD),
    .i_d(w_d_in), .o_q(w_d_q)
  );

  pipe_stage_reg #(.T(stage_t), .BUBBLE(BUBBLE)) u_stage_e (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(StallE), .i_flush(FlushE),
    .i_d(w_e_in), .o_q(w_e_q)
  );

  pipe_stage_reg #(.T(stage_t), .BUBBLE(BUBBLE)) u_stage_m (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(StallM), .i_flush(FlushM),
    .i_d(w_m_in), .o_q(w_m_q)
  );

  pipe_stage_reg #(.T(stage_t), .BUBBLE(BUBBLE)) u_stage_w (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(StallW), .i_flush(FlushW),
    .i_d(w_m_q), .o_q(w_w_q)
  );

  // Payload fields that are always zero in their stage and never leave the block.
  logic w_unused;
  assign w_unused = ^{w_d_q.rd_wren, w_d_q.wb_sel, w_d_q.opa_sel, w_d_q.pc_sel,
                      w_w_q.opa_sel, w_w_q.pc_sel};

  // Performance counters; 32-bit adds wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      // retire when W holds a real instruction that is leaving this cycle
      if (w_w_q.valid && !StallW) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
      if (StallF || StallD) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      // one count per cycle regardless of how many stages flush
      if (FlushD || FlushE || FlushM || FlushW) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign pc_F        = r_pc_f;
  assign pc_D        = w_d_q.pc;
  assign pc_E        = w_e_q.pc;
  assign pc_M        = w_m_q.pc;
  assign pc_W        = w_w_q.pc;
  assign instr_D     = w_d_q.instr;
  assign instr_E     = w_e_q.instr;
  assign instr_M     = w_m_q.instr;
  assign instr_W     = w_w_q.instr;
  assign valid_D     = w_d_q.valid;
  assign valid_E     = w_e_q.valid;
  assign valid_M     = w_m_q.valid;
  assign valid_W     = w_w_q.valid;
  assign rd_wren_E   = w_e_q.rd_wren;
  assign rd_wren_M   = w_m_q.rd_wren;
  assign rd_wren_W   = w_w_q.rd_wren;
  assign wb_sel_E    = w_e_q.wb_sel;
  assign wb_sel_M    = w_m_q.wb_sel;
  assign wb_sel_W    = w_w_q.wb_sel;
  assign opa_sel_E   = w_e_q.opa_sel;
  assign pc_sel_E    = w_e_q.pc_sel;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction inserted on flush or reset.
REQ-003 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 pc_next_F  input  32  next PC selected by fetch logic.
REQ-006 instr_F  input  32  instruction read at pc_F.
REQ-007 StallF, StallD, StallE, StallM, StallW  input  1 each  hold request per stage from the hazard unit.
REQ-008 FlushD, FlushE, FlushM, FlushW  input  1 each  bubble request per stage from the hazard unit.
REQ-009 rd_wren_D, opa_sel_D, pc_sel_D  input  1 each  decoded D-stage controls; wb_sel_D  input  2  decoded writeback select.
REQ-010 pc_F  output  32  fetch PC register.
REQ-011 pc_D/E/M/W, instr_D/E/M/W  output  32 each  per-stage PC and instruction.
REQ-012 rd_wren_E/M/W, opa_sel_E, pc_sel_E  output  1 each; wb_sel_E/M/W  output  2 each  pipelined controls.
REQ-013 valid_D/E/M/W  output  1 each  stage holds a real (non-bubble) instruction.
REQ-014 cycle_cnt, instret_cnt, stall_cnt, flush_cnt  output  32 each  performance counters.

Function
REQ-015 Each stage register X (F,D,E,M,W) SHALL update once per cycle: if FlushX load bubble; else if StallX hold; else load from preceding stage.
REQ-016 Flush SHALL take priority over stall in the same stage in the same cycle.
REQ-017 pc_F SHALL load pc_next_F unless StallF; F has no flush.
REQ-018 D load SHALL capture pc_F, instr_F, valid_D=1.
REQ-019 E load SHALL capture pc_D, instr_D, valid_D and all *_D controls; M and W SHALL shift E->M->W likewise (pc, instr, valid, rd_wren, wb_sel).
REQ-020 A bubble SHALL set instr to NOP_INSTR, pc to 0, valid to 0, and rd_wren, opa_sel, pc_sel, wb_sel to 0.
REQ-021 Latency F->W SHALL be exactly 4 cycles with no stall/flush.
REQ-022 A held stage whose successor advances SHALL NOT be duplicated unless the successor's flush is absent; hazard unit owns this pairing (StallD with FlushE yields one bubble in E per stall cycle).
REQ-023 cycle_cnt SHALL increment by 1 every cycle out of reset.
REQ-024 instret_cnt SHALL increment when valid_W=1 and StallW=0 in that cycle.
REQ-025 stall_cnt SHALL increment in each cycle StallF or StallD is 1.
REQ-026 flush_cnt SHALL increment by 1 in each cycle any FlushD/E/M/W is 1 (not per stage).
REQ-027 All counters SHALL wrap 32'hFFFF_FFFF -> 0 silently.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 On i_reset=1 at a clock edge: pc_F=RESET_PC; all D/E/M/W stages bubble per REQ-020; all counters 0.
REQ-030 i_reset SHALL override all stall and flush inputs, including mid-stall.
REQ-031 First cycle after reset release SHALL load instr_F into D (valid_D=1 next edge).

Structure
REQ-032 NOP_INSTR value, opcode constants (LOAD 7'b0000011, BRANCH 7'b1100011) and a stage-payload struct (pc, instr, valid, rd_wren, wb_sel, opa_sel, pc_sel) SHALL live in the shared pipeline package.
REQ-033 One sub-module pipe_stage_reg (parameterised payload, stall, flush, bubble value) SHALL be instantiated per stage D/E/M/W; counters in top.

Verification
REQ-034 Reset then feed instr 0x00500093 at pc 0 with no hazards -> instr_W=0x00500093, valid_W=1 four cycles later; instret_cnt=1 next cycle.
REQ-035 StallF=StallD=FlushE=1 for one cycle with lw in E -> pc_F, instr_D held; instr_E=0x00000013, valid_E=0; stall_cnt=1.
REQ-036 FlushD=1 and StallD=1 same cycle -> valid_D=0, instr_D=NOP_INSTR (flush wins).
REQ-037 Assert i_reset during a 3-cycle stall -> next edge pc_F=RESET_PC, all valid_*=0, all counters 0.
REQ-038 Preload cycle_cnt to 32'hFFFF_FFFF via force -> next cycle cycle_cnt=0, no other output disturbed.
REQ-039 Branch taken: FlushD=FlushE=1 one cycle -> two bubbles reach W on consecutive cycles, instret_cnt does not increment for them, flush_cnt=1.
